// File: rtl/kronos_decode.sv
// kronos_decode: RV32I/RV32E instruction decoder between IF and EX.
//
// Accepts one fetched instruction per fetch handshake, selects the ALU
// operation and operands, and registers them into the ID/EX pipe register.
// A pending-write scoreboard (one bit per architectural register, x0 never
// pending) stalls RAW and WAW hazards against in-flight instructions.
//
// Optional feature macro: KRONOS_DECODE_FORWARD_EN
//   defined   : a register written back this cycle is not treated as pending,
//               and its regwr_data is captured in place of the stale
//               register file read.
//   undefined : write-back data is never forwarded; an instruction reading a
//               register being written back this cycle stalls one cycle so
//               the register file read sees the new value.
//
// Ports:
//   clk, rstz                 clock, asynchronous active-low reset
//   flush                     drop the ID/EX entry (wins over a capture)
//   fetch, immediate          fetched pc/ir and its decoded immediate
//   regrd_rs1/2, *_en         register file read data and use flags
//   fetch_vld / fetch_rdy     IF -> ID handshake
//   decode, decode_rd,
//   decode_regwr,
//   decode_illegal            ID/EX payload
//   decode_vld / decode_rdy   ID -> EX handshake
//   regwr_data/sel/en         write-back port (clears scoreboard bits)
//   hazard_stall              combinational: fetch_vld and a hazard blocks
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready of the same port,
// and a valid payload is held stable until it is accepted or flushed.

package kronos_decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic        regwr_alu;
  } pipeIDEX_t;
endpackage

module kronos_decode
  import kronos_decode_pkg::*;
#(
  parameter int   NUM_REGS            = 32,
  parameter logic CATCH_ILLEGAL_INSTR = 1'b1
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic              flush,
  input  pipeIFID_t         fetch,
  input  logic [31:0]       immediate,
  input  logic [31:0]       regrd_rs1,
  input  logic [31:0]       regrd_rs2,
  input  logic              regrd_rs1_en,
  input  logic              regrd_rs2_en,
  input  logic              fetch_vld,
  output logic              fetch_rdy,
  output pipeIDEX_t         decode,
  output logic [4:0]        decode_rd,
  output logic              decode_regwr,
  output logic              decode_illegal,
  output logic              decode_vld,
  input  logic              decode_rdy,
  input  logic [31:0]       regwr_data,
  input  logic [4:0]        regwr_sel,
  input  logic              regwr_en,
  output logic              hazard_stall
);

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYS     = 5'b11100;

  localparam logic [3:0]  ALU_ADD = 4'b0000;
  localparam logic [31:0] FOUR    = 32'd4;

  // Field extraction
  logic [4:0] opcode, rd, rs1, rs2;
  logic [2:0] funct3;
  logic       funct7_5;

  assign opcode   = fetch.ir[6:2];
  assign rd       = fetch.ir[11:7];
  assign funct3   = fetch.ir[14:12];
  assign rs1      = fetch.ir[19:15];
  assign rs2      = fetch.ir[24:20];
  assign funct7_5 = fetch.ir[30];

  // Scoreboard, kept at NUM_REGS bits but looked up through a 32-bit view so
  // 5-bit register fields never index out of range in the RV32E build.
  logic [NUM_REGS-1:0] pending;
  logic [31:0]         pend32, pend_nxt, p_eff;
  logic                fwd_rs1, fwd_rs2, wb_stall;

  assign pend32 = 32'(pending);

`ifdef KRONOS_DECODE_FORWARD_EN
  assign p_eff    = pend32 & ~(regwr_en ? (32'd1 << regwr_sel) : 32'd0);
  assign fwd_rs1  = regrd_rs1_en && regwr_en && (regwr_sel != 5'd0) && (regwr_sel == rs1);
  assign fwd_rs2  = regrd_rs2_en && regwr_en && (regwr_sel != 5'd0) && (regwr_sel == rs2);
  assign wb_stall = 1'b0;
`else
  assign p_eff    = pend32;
  assign fwd_rs1  = 1'b0;
  assign fwd_rs2  = 1'b0;
  // The register file only shows the new value the cycle after write-back.
  assign wb_stall = regwr_en && ((regrd_rs1_en && (rs1 == regwr_sel)) ||
                                 (regrd_rs2_en && (rs2 == regwr_sel)));
  logic unused_wb_data;
  assign unused_wb_data = ^regwr_data;
`endif

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = fwd_rs1 ? regwr_data : regrd_rs1;
  assign rs2_val = fwd_rs2 ? regwr_data : regrd_rs2;

  // Opcode decode: write intent, operand selection, ALU op, legality
  logic        wr_op, alu_wr_op, legal_op;
  logic [3:0]  aluop;
  logic [31:0] op1, op2;

  always_comb begin
    wr_op     = 1'b0;
    alu_wr_op = 1'b0;
    legal_op  = 1'b1;
    aluop     = ALU_ADD;
    op1       = fetch.pc;
    op2       = FOUR;
    case (opcode)
      OP_LUI: begin
        wr_op = 1'b1; alu_wr_op = 1'b1;
        op1 = 32'd0; op2 = immediate;
      end
      OP_AUIPC: begin
        wr_op = 1'b1; alu_wr_op = 1'b1;
        op2 = immediate;
      end
      OP_JAL, OP_JALR: begin
        wr_op = 1'b1; alu_wr_op = 1'b1;
      end
      OP_OPIMM: begin
        wr_op = 1'b1; alu_wr_op = 1'b1;
        op1 = rs1_val; op2 = immediate;
        // Only the shifts use ir[30] as an opcode bit; otherwise it is imm.
        aluop = (funct3 == 3'd1 || funct3 == 3'd5) ? {funct7_5, funct3} : {1'b0, funct3};
      end
      OP_OP: begin
        wr_op = 1'b1; alu_wr_op = 1'b1;
        op1 = rs1_val; op2 = rs2_val;
        aluop = {funct7_5, funct3};
      end
      OP_LOAD: wr_op = 1'b1;
      OP_SYS:  wr_op = (funct3 != 3'd0) && (funct3 != 3'd4);
      OP_BRANCH, OP_STORE, OP_MISCMEM: ;
      default: legal_op = 1'b0;
    endcase
  end

  logic is_reg_write, regwr_alu, rv32e_bad, illegal;

  assign is_reg_write = wr_op && (rd != 5'd0);
  assign regwr_alu    = alu_wr_op && (rd != 5'd0);
  assign rv32e_bad    = (NUM_REGS == 16) && ((regrd_rs1_en && rs1[4]) ||
                                             (regrd_rs2_en && rs2[4]) ||
                                             (is_reg_write && rd[4]));
  assign illegal      = CATCH_ILLEGAL_INSTR &&
                        ((fetch.ir[1:0] != 2'b11) || !legal_op || rv32e_bad);

  // Hazard and handshake
  assign hazard_stall = fetch_vld && ((regrd_rs1_en && p_eff[rs1]) ||
                                      (regrd_rs2_en && p_eff[rs2]) ||
                                      (is_reg_write && p_eff[rd]) ||
                                      wb_stall);
  assign fetch_rdy = (~decode_vld | decode_rdy) & ~hazard_stall;

  logic capture, sb_set;
  assign capture = fetch_vld && fetch_rdy && ~flush;
  assign sb_set  = capture && is_reg_write && ~illegal;

  // Clears first, set last: a same-cycle set of the same bit wins.
  always_comb begin
    pend_nxt = pend32;
    if (regwr_en)
      pend_nxt[regwr_sel] = 1'b0;
    if (flush && decode_vld && decode_regwr)
      pend_nxt[decode_rd] = 1'b0;
    if (sb_set)
      pend_nxt[rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  logic unused_pend;
  assign unused_pend = ^pend_nxt;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      pending        <= '0;
      decode         <= '0;
      decode_rd      <= 5'd0;
      decode_regwr   <= 1'b0;
      decode_illegal <= 1'b0;
      decode_vld     <= 1'b0;
    end else begin
      pending <= pend_nxt[NUM_REGS-1:0];
      if (capture) begin
        decode.pc        <= fetch.pc;
        decode.ir        <= fetch.ir;
        decode.op1       <= op1;
        decode.op2       <= op2;
        decode.aluop     <= aluop;
        decode.regwr_alu <= regwr_alu && ~illegal;
        decode_rd        <= rd;
        decode_regwr     <= is_reg_write && ~illegal;
        decode_illegal   <= illegal;
        decode_vld       <= 1'b1;
      end else if (flush || decode_rdy) begin
        decode_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kronos_decode.sv
// tb_kronos_decode: directed bench for kronos_decode.
// Two instances share all inputs: dut (RV32I, 32 registers) and dut_e
// (RV32E, 16 registers). Expectations that depend on write-back forwarding
// follow the KRONOS_DECODE_FORWARD_EN macro.

module tb_kronos_decode;
  import kronos_decode_pkg::*;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  logic        flush;
  pipeIFID_t   fetch;
  logic [31:0] immediate, regrd_rs1, regrd_rs2, regwr_data;
  logic        regrd_rs1_en, regrd_rs2_en, fetch_vld, decode_rdy, regwr_en;
  logic [4:0]  regwr_sel;

  logic        fetch_rdy, decode_regwr, decode_illegal, decode_vld, hazard_stall;
  pipeIDEX_t   decode;
  logic [4:0]  decode_rd;

  logic        e_fetch_rdy, e_decode_regwr, e_decode_illegal, e_decode_vld, e_hazard_stall;
  pipeIDEX_t   e_decode;
  logic [4:0]  e_decode_rd;

  int n_cmp = 0;
  int n_err = 0;

  kronos_decode #(.NUM_REGS(32), .CATCH_ILLEGAL_INSTR(1'b1)) dut (
    .clk(clk), .rstz(rstz), .flush(flush), .fetch(fetch), .immediate(immediate),
    .regrd_rs1(regrd_rs1), .regrd_rs2(regrd_rs2),
    .regrd_rs1_en(regrd_rs1_en), .regrd_rs2_en(regrd_rs2_en),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .decode(decode),
    .decode_rd(decode_rd), .decode_regwr(decode_regwr), .decode_illegal(decode_illegal),
    .decode_vld(decode_vld), .decode_rdy(decode_rdy), .regwr_data(regwr_data),
    .regwr_sel(regwr_sel), .regwr_en(regwr_en), .hazard_stall(hazard_stall)
  );

  kronos_decode #(.NUM_REGS(16), .CATCH_ILLEGAL_INSTR(1'b1)) dut_e (
    .clk(clk), .rstz(rstz), .flush(flush), .fetch(fetch), .immediate(immediate),
    .regrd_rs1(regrd_rs1), .regrd_rs2(regrd_rs2),
    .regrd_rs1_en(regrd_rs1_en), .regrd_rs2_en(regrd_rs2_en),
    .fetch_vld(fetch_vld), .fetch_rdy(e_fetch_rdy), .decode(e_decode),
    .decode_rd(e_decode_rd), .decode_regwr(e_decode_regwr), .decode_illegal(e_decode_illegal),
    .decode_vld(e_decode_vld), .decode_rdy(decode_rdy), .regwr_data(regwr_data),
    .regwr_sel(regwr_sel), .regwr_en(regwr_en), .hazard_stall(e_hazard_stall)
  );

  // Instruction encoders
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    flush = 1'b0; fetch = '0; immediate = '0; regrd_rs1 = '0; regrd_rs2 = '0;
    regrd_rs1_en = 1'b0; regrd_rs2_en = 1'b0; fetch_vld = 1'b0; decode_rdy = 1'b1;
    regwr_data = '0; regwr_sel = '0; regwr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstz = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rstz = 1'b1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] imm, input logic e1,
                       input logic e2, input logic [31:0] pc);
    fetch.pc = pc; fetch.ir = ir; immediate = imm;
    regrd_rs1_en = e1; regrd_rs2_en = e2; fetch_vld = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstz = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %h exp 0", decode_vld); end
    n_cmp++; if (decode !== pipeIDEX_t'('0)) begin n_err++; $display("FAIL rst_decode got %h exp 0", decode); end
    n_cmp++; if (decode_rd !== 5'd0) begin n_err++; $display("FAIL rst_rd got %h exp 0", decode_rd); end
    n_cmp++; if (decode_regwr !== 1'b0) begin n_err++; $display("FAIL rst_regwr got %h exp 0", decode_regwr); end
    n_cmp++; if (decode_illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %h exp 0", decode_illegal); end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL rst_pending got %h exp 0", dut.pending); end
    n_cmp++; if (dut_e.pending !== 16'h0) begin n_err++; $display("FAIL rst_e_pending got %h exp 0", dut_e.pending); end
    n_cmp++; if (fetch_rdy !== 1'b1) begin n_err++; $display("FAIL rst_fetch_rdy got %h exp 1", fetch_rdy); end
    @(negedge clk);
    rstz = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(i_type(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd5, 1'b1, 1'b0, 32'h100);
    #1;
    n_cmp++; if (fetch_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy got %h exp 1", fetch_rdy); end
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL b2b_haz got %h exp 0", hazard_stall); end
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld1 got %h exp 1", decode_vld); end
    n_cmp++; if (decode.op2 !== 32'd5) begin n_err++; $display("FAIL b2b_op2_1 got %h exp 5", decode.op2); end
    n_cmp++; if (decode.op1 !== 32'd0) begin n_err++; $display("FAIL b2b_op1_1 got %h exp 0", decode.op1); end
    n_cmp++; if (decode_rd !== 5'd1) begin n_err++; $display("FAIL b2b_rd1 got %h exp 1", decode_rd); end
    n_cmp++; if (decode.pc !== 32'h100) begin n_err++; $display("FAIL b2b_pc1 got %h exp 100", decode.pc); end
    n_cmp++; if (decode.regwr_alu !== 1'b1) begin n_err++; $display("FAIL b2b_alu1 got %h exp 1", decode.regwr_alu); end
    issue(i_type(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd7, 1'b1, 1'b0, 32'h104);
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld2 got %h exp 1", decode_vld); end
    n_cmp++; if (decode.op2 !== 32'd7) begin n_err++; $display("FAIL b2b_op2_2 got %h exp 7", decode.op2); end
    n_cmp++; if (decode_rd !== 5'd2) begin n_err++; $display("FAIL b2b_rd2 got %h exp 2", decode_rd); end
    fetch_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %h exp 0", decode_vld); end
    n_cmp++; if (dut.pending !== 32'h6) begin n_err++; $display("FAIL b2b_pending got %h exp 6", dut.pending); end
  endtask

  typedef struct {
    logic [31:0] ir, imm, op1, op2;
    logic [3:0]  aluop;
    logic        e1, e2, regwr, alu;
  } vec_t;

  task automatic test_decode_table();
    vec_t tbl[12];
    tbl[0]  = '{r_type(7'b0100000, 5'd7, 5'd6, 3'b000, 5'd5), 32'h0, 32'h11110000, 32'h22220000, 4'h8, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{i_type(12'h403, 5'd6, 3'b101, 5'd12, 7'b0010011), 32'h403, 32'h11110000, 32'h403, 4'hd, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{i_type(12'h400, 5'd0, 3'b000, 5'd13, 7'b0010011), 32'h400, 32'h11110000, 32'h400, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{i_type(12'h0ff, 5'd0, 3'b111, 5'd14, 7'b0010011), 32'hff, 32'h11110000, 32'hff, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{u_type(20'h00001, 5'd8, 7'b0010111), 32'h1000, 32'h210, 32'h1000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{u_type(20'h00000, 5'd15, 7'b1101111), 32'h0, 32'h214, 32'h4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{i_type(12'h000, 5'd0, 3'b010, 5'd9, 7'b0000011), 32'h0, 32'h218, 32'h4, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{i_type(12'h300, 5'd0, 3'b001, 5'd10, 7'b1110011), 32'h300, 32'h21c, 32'h4, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{32'h00000073, 32'h0, 32'h220, 32'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000063, 32'h0, 32'h224, 32'h4, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{i_type(12'h000, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'h11110000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{i_type(12'h001, 5'd0, 3'b001, 5'd16, 7'b0010011), 32'h1, 32'h11110000, 32'h1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    regrd_rs1 = 32'h11110000;
    regrd_rs2 = 32'h22220000;
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].ir, tbl[i].imm, tbl[i].e1, tbl[i].e2, 32'h200 + 32'(i) * 32'd4);
      @(negedge clk);
      n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL tbl%0d_vld got %h exp 1", i, decode_vld); end
      n_cmp++; if (decode.ir !== tbl[i].ir) begin n_err++; $display("FAIL tbl%0d_ir got %h exp %h", i, decode.ir, tbl[i].ir); end
      n_cmp++; if (decode.op1 !== tbl[i].op1) begin n_err++; $display("FAIL tbl%0d_op1 got %h exp %h", i, decode.op1, tbl[i].op1); end
      n_cmp++; if (decode.op2 !== tbl[i].op2) begin n_err++; $display("FAIL tbl%0d_op2 got %h exp %h", i, decode.op2, tbl[i].op2); end
      n_cmp++; if (decode.aluop !== tbl[i].aluop) begin n_err++; $display("FAIL tbl%0d_aluop got %h exp %h", i, decode.aluop, tbl[i].aluop); end
      n_cmp++; if (decode_regwr !== tbl[i].regwr) begin n_err++; $display("FAIL tbl%0d_regwr got %h exp %h", i, decode_regwr, tbl[i].regwr); end
      n_cmp++; if (decode.regwr_alu !== tbl[i].alu) begin n_err++; $display("FAIL tbl%0d_alu got %h exp %h", i, decode.regwr_alu, tbl[i].alu); end
      n_cmp++; if (decode_illegal !== 1'b0) begin n_err++; $display("FAIL tbl%0d_illegal got %h exp 0", i, decode_illegal); end
    end
    fetch_vld = 1'b0;
  endtask

  task automatic test_raw();
    do_reset();
    issue(i_type(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd1, 1'b1, 1'b0, 32'h2fc);
    @(negedge clk);
    issue(r_type(7'b0, 5'd1, 5'd1, 3'b000, 5'd3), 32'h0, 1'b1, 1'b1, 32'h300);
    regrd_rs1 = 32'hAAAAAAAA; regrd_rs2 = 32'hAAAAAAAA;
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall got %h exp 1", hazard_stall); end
    n_cmp++; if (fetch_rdy !== 1'b0) begin n_err++; $display("FAIL raw_rdy got %h exp 0", fetch_rdy); end
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL raw_hold_vld got %h exp 0", decode_vld); end
    regwr_en = 1'b1; regwr_sel = 5'd1; regwr_data = 32'd9;
    #1;
`ifdef KRONOS_DECODE_FORWARD_EN
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL raw_fwd_stall got %h exp 0", hazard_stall); end
    @(negedge clk);
    regwr_en = 1'b0; fetch_vld = 1'b0;
`else
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL raw_wb_stall got %h exp 1", hazard_stall); end
    @(negedge clk);
    regwr_en = 1'b0;
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL raw_wb_vld got %h exp 0", decode_vld); end
    regrd_rs1 = 32'd9; regrd_rs2 = 32'd9;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL raw_after_stall got %h exp 0", hazard_stall); end
    @(negedge clk);
    fetch_vld = 1'b0;
`endif
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL raw_vld got %h exp 1", decode_vld); end
    n_cmp++; if (decode.op1 !== 32'd9) begin n_err++; $display("FAIL raw_op1 got %h exp 9", decode.op1); end
    n_cmp++; if (decode.op2 !== 32'd9) begin n_err++; $display("FAIL raw_op2 got %h exp 9", decode.op2); end
    n_cmp++; if (decode_rd !== 5'd3) begin n_err++; $display("FAIL raw_rd got %h exp 3", decode_rd); end
    n_cmp++; if (dut.pending !== 32'h8) begin n_err++; $display("FAIL raw_pending got %h exp 8", dut.pending); end
  endtask

  task automatic test_flush();
    do_reset();
    decode_rdy = 1'b0;
    issue(u_type(20'h12345, 5'd4, 7'b0110111), 32'h12345000, 1'b0, 1'b0, 32'h400);
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL lui_vld got %h exp 1", decode_vld); end
    n_cmp++; if (decode.op1 !== 32'd0) begin n_err++; $display("FAIL lui_op1 got %h exp 0", decode.op1); end
    n_cmp++; if (decode.op2 !== 32'h12345000) begin n_err++; $display("FAIL lui_op2 got %h exp 12345000", decode.op2); end
    n_cmp++; if (decode_regwr !== 1'b1) begin n_err++; $display("FAIL lui_regwr got %h exp 1", decode_regwr); end
    n_cmp++; if (dut.pending !== 32'h10) begin n_err++; $display("FAIL lui_pending got %h exp 10", dut.pending); end
    // flush together with an acceptable fetch: flush wins, nothing captured
    issue(i_type(12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'd1, 1'b1, 1'b0, 32'h404);
    decode_rdy = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL flush_vld got %h exp 0", decode_vld); end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL flush_pending got %h exp 0", dut.pending); end
    issue(r_type(7'b0, 5'd4, 5'd4, 3'b000, 5'd5), 32'h0, 1'b1, 1'b1, 32'h408);
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL flush_next_stall got %h exp 0", hazard_stall); end
    @(negedge clk);
    fetch_vld = 1'b0;
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL flush_next_vld got %h exp 1", decode_vld); end
    n_cmp++; if (decode_rd !== 5'd5) begin n_err++; $display("FAIL flush_next_rd got %h exp 5", decode_rd); end
  endtask

  task automatic test_illegal_rv32e();
    do_reset();
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd17), 32'h0, 1'b1, 1'b1, 32'h600);
    @(negedge clk);
    n_cmp++; if (e_decode_vld !== 1'b1) begin n_err++; $display("FAIL e_x17_vld got %h exp 1", e_decode_vld); end
    n_cmp++; if (e_decode_illegal !== 1'b1) begin n_err++; $display("FAIL e_x17_illegal got %h exp 1", e_decode_illegal); end
    n_cmp++; if (e_decode_regwr !== 1'b0) begin n_err++; $display("FAIL e_x17_regwr got %h exp 0", e_decode_regwr); end
    n_cmp++; if (e_decode.regwr_alu !== 1'b0) begin n_err++; $display("FAIL e_x17_alu got %h exp 0", e_decode.regwr_alu); end
    n_cmp++; if (dut_e.pending !== 16'h0) begin n_err++; $display("FAIL e_x17_pending got %h exp 0", dut_e.pending); end
    n_cmp++; if (decode_illegal !== 1'b0) begin n_err++; $display("FAIL i_x17_illegal got %h exp 0", decode_illegal); end
    n_cmp++; if (decode_regwr !== 1'b1) begin n_err++; $display("FAIL i_x17_regwr got %h exp 1", decode_regwr); end
    issue(32'h00000001, 32'h0, 1'b0, 1'b0, 32'h604);
    @(negedge clk);
    n_cmp++; if (e_decode_illegal !== 1'b1) begin n_err++; $display("FAIL e_rvc_illegal got %h exp 1", e_decode_illegal); end
    n_cmp++; if (decode_illegal !== 1'b1) begin n_err++; $display("FAIL i_rvc_illegal got %h exp 1", decode_illegal); end
    issue(32'h0000007F, 32'h0, 1'b0, 1'b0, 32'h608);
    @(negedge clk);
    n_cmp++; if (decode_illegal !== 1'b1) begin n_err++; $display("FAIL bad_opcode_illegal got %h exp 1", decode_illegal); end
    issue(i_type(12'd1, 5'd1, 3'b000, 5'd3, 7'b0010011), 32'd1, 1'b1, 1'b0, 32'h60c);
    @(negedge clk);
    fetch_vld = 1'b0;
    n_cmp++; if (e_decode_illegal !== 1'b0) begin n_err++; $display("FAIL e_legal_illegal got %h exp 0", e_decode_illegal); end
    n_cmp++; if (e_decode_regwr !== 1'b1) begin n_err++; $display("FAIL e_legal_regwr got %h exp 1", e_decode_regwr); end
  endtask

  task automatic test_backpressure_waw();
    do_reset();
    decode_rdy = 1'b0;
    issue(i_type(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd5, 1'b1, 1'b0, 32'h500);
    @(negedge clk);
    issue(i_type(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd7, 1'b1, 1'b0, 32'h504);
    #1;
    n_cmp++; if (fetch_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy got %h exp 0", fetch_rdy); end
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL bp_stall got %h exp 0", hazard_stall); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_vld got %h exp 1", c, decode_vld); end
      n_cmp++; if (decode.op2 !== 32'd5) begin n_err++; $display("FAIL bp_hold%0d_op2 got %h exp 5", c, decode.op2); end
      n_cmp++; if (decode.pc !== 32'h500) begin n_err++; $display("FAIL bp_hold%0d_pc got %h exp 500", c, decode.pc); end
    end
    decode_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (decode_rd !== 5'd2) begin n_err++; $display("FAIL bp_next_rd got %h exp 2", decode_rd); end
    n_cmp++; if (decode.op2 !== 32'd7) begin n_err++; $display("FAIL bp_next_op2 got %h exp 7", decode.op2); end
    issue(i_type(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd3, 1'b1, 1'b0, 32'h508);
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got %h exp 1", hazard_stall); end
    n_cmp++; if (fetch_rdy !== 1'b0) begin n_err++; $display("FAIL waw_rdy got %h exp 0", fetch_rdy); end
    @(negedge clk);
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL waw_hold_vld got %h exp 0", decode_vld); end
    regwr_en = 1'b1; regwr_sel = 5'd1; regwr_data = 32'd0;
    #1;
`ifdef KRONOS_DECODE_FORWARD_EN
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL waw_fwd_stall got %h exp 0", hazard_stall); end
    @(negedge clk);
    regwr_en = 1'b0; fetch_vld = 1'b0;
`else
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL waw_wb_stall got %h exp 1", hazard_stall); end
    @(negedge clk);
    regwr_en = 1'b0;
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL waw_wb_vld got %h exp 0", decode_vld); end
    @(negedge clk);
    fetch_vld = 1'b0;
`endif
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL waw_vld got %h exp 1", decode_vld); end
    n_cmp++; if (decode_rd !== 5'd1) begin n_err++; $display("FAIL waw_rd got %h exp 1", decode_rd); end
    n_cmp++; if (decode.op2 !== 32'd3) begin n_err++; $display("FAIL waw_op2 got %h exp 3", decode.op2); end
    n_cmp++; if (dut.pending !== 32'h6) begin n_err++; $display("FAIL waw_pending got %h exp 6", dut.pending); end
  endtask

  task automatic test_reset_mid_stall();
    // x1 and x2 are still pending from the previous scenario
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 1'b1, 1'b1, 32'h700);
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL rms_stall got %h exp 1", hazard_stall); end
    @(negedge clk);
    rstz = 1'b0;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL rms_rst_stall got %h exp 0", hazard_stall); end
    n_cmp++; if (dut.pending !== 32'h0) begin n_err++; $display("FAIL rms_rst_pending got %h exp 0", dut.pending); end
    n_cmp++; if (decode_vld !== 1'b0) begin n_err++; $display("FAIL rms_rst_vld got %h exp 0", decode_vld); end
    @(negedge clk);
    rstz = 1'b1;
    @(negedge clk);
    fetch_vld = 1'b0;
    n_cmp++; if (decode_vld !== 1'b1) begin n_err++; $display("FAIL rms_vld got %h exp 1", decode_vld); end
    n_cmp++; if (decode_rd !== 5'd3) begin n_err++; $display("FAIL rms_rd got %h exp 3", decode_rd); end
    n_cmp++; if (dut.pending !== 32'h8) begin n_err++; $display("FAIL rms_pending got %h exp 8", dut.pending); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_decode_table();
    test_raw();
    test_flush();
    test_illegal_rv32e();
    test_backpressure_waw();
    test_reset_mid_stall();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kronos_decode.md
# kronos_decode

Parametrised RV32I/RV32E instruction decoder for the Kronos core, sitting between fetch (IF) and execute (EX). It accepts one fetched instruction per handshake, selects the ALU operation and operands, and registers them into the ID/EX pipe register. A per-register pending-write scoreboard stalls RAW and WAW hazards against in-flight instructions. Optional write-back forwarding avoids a stall when a register is written back in the same cycle it is read.

## Interface
- NUM_REGS, 32: architectural register count; 32 (RV32I) or 16 (RV32E).
- CATCH_ILLEGAL_INSTR, 1: when 1, illegal instructions raise decode_illegal; when 0, decode_illegal is tied to 0.
- clk  in  1  clock.
- rstz  in  1  reset, asynchronous, active-low.
- flush  in  1  kill the ID/EX register; the entry is dropped.
- fetch  in  pipeIFID_t  fetched pc and ir.
- immediate  in  32  immediate decoded from fetch.ir.
- regrd_rs1 / regrd_rs2  in  32 each  register file read data.
- regrd_rs1_en / regrd_rs2_en  in  1 each  instruction uses rs1/rs2.
- fetch_vld  in  1  fetch payload valid.
- fetch_rdy  out  1  decoder accepts fetch.
- decode  out  pipeIDEX_t  pc, ir, op1, op2, aluop, regwr_alu.
- decode_rd  out  5  destination register of the entry.
- decode_regwr  out  1  entry writes decode_rd; covers ALU, load and CSR writes.
- decode_illegal  out  1  entry is an illegal instruction.
- decode_vld  out  1  ID/EX valid.
- decode_rdy  in  1  EX accepts the entry.
- regwr_data  in  32  write-back data.
- regwr_sel  in  5  write-back register.
- regwr_en  in  1  write-back strobe.
- hazard_stall  out  1  combinational; fetch_vld is high and a hazard is blocking.

## Operation
- **Field extraction.** OP = ir[6:2], rd = ir[11:7], rs1 = ir[19:15], rs2 = ir[24:20], funct3 = ir[14:12], funct7 = ir[31:25].
- **is_reg_write.** rd != 0 and OP is one of LUI, AUIPC, JAL, JALR, OPIMM, OP, LOAD, or SYS with funct3 in {1,2,3,5,6,7}.
- **regwr_alu.** Same condition, but excluding LOAD and SYS.
- **aluop.**
  - Default is ADD.
  - OP: {funct7[5], funct3}.
  - OPIMM: {funct7[5], funct3} for funct3 in {1,5}; {0, funct3} otherwise.
- **Operands.**
  - Default op1 = PC, op2 = FOUR.
  - LUI: op1 = ZERO, op2 = imm.
  - AUIPC: op2 = imm.
  - OPIMM: op1 = rs1, op2 = imm.
  - OP: op1 = rs1, op2 = rs2.
- **Illegal instruction.** Raised when ir[1:0] != 2'b11, or OP is not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM, SYS}, or (NUM_REGS == 16 and any used rs or a written rd has bit 4 set). Illegal entries are forced to decode_regwr = 0 and regwr_alu = 0.
- **Scoreboard.** pending[NUM_REGS-1:1] holds one bit per register; x0 is never pending.
  - Set pending[rd] on a fetch handshake when is_reg_write and the entry is not illegal.
  - Clear pending[regwr_sel] when regwr_en.
  - On flush with decode_vld && decode_regwr, clear pending[decode_rd].
  - Set and clear of the same bit in one cycle: set wins.
- **Hazard.** hazard_stall = fetch_vld && ((regrd_rs1_en && P[rs1]) || (regrd_rs2_en && P[rs2]) || (is_reg_write && P[rd])), where P is the effective pending vector (see Configuration).
- **Handshake.**
  - fetch_rdy = (~decode_vld | decode_rdy) & ~hazard_stall.
  - The entry is captured when fetch_vld && fetch_rdy && ~flush.
  - flush has priority: decode_vld goes to 0, no capture, no scoreboard set.
  - decode_vld clears on decode_rdy when no new capture occurs.

## Timing
- Latency is 1 cycle from the fetch handshake to decode_vld.
- Full throughput: 1 instruction per cycle with no hazards.
- Reset values:
  - decode_vld = 0, pending = 0.
  - decode, decode_rd, decode_regwr, decode_illegal = 0.
- A hazard resolves on the cycle regwr_en clears the bit (with forwarding), or the cycle after (without forwarding).
- Reset mid-stall drops all state; the first post-reset instruction sees no pending registers.

## Configuration
- Macro: KRONOS_DECODE_FORWARD_EN.
- **Defined.**
  - P = pending & ~(regwr_en ? onehot(regwr_sel) : 0).
  - Any used rs equal to a nonzero regwr_sel with regwr_en captures regwr_data in place of regrd_rsN.
- **Undefined.**
  - P = pending.
  - Operands always come from regrd_rsN.
  - Additionally stall when a used rs equals regwr_sel with regwr_en, so the register file is read one cycle after write-back.

## Test plan
- **Back-to-back ALU.** ADDI x1,x0,5 then ADDI x2,x0,7 with decode_rdy = 1 -> two consecutive decode_vld cycles, op2 = 5 then 7, pending = {x1, x2}.
- **RAW, forwarding on.** ADDI x1 in EX; ADD x3,x1,x1 waits with hazard_stall = 1. regwr_en with regwr_sel = 1, regwr_data = 9 -> captured that cycle, op1 = op2 = 9.
- **RAW, forwarding off.** Same sequence -> capture one cycle after regwr_en, using regrd_rs1.
- **Flush.** LUI x4 in ID/EX, flush = 1 -> decode_vld = 0, pending[4] = 0, and the next instruction reading x4 does not stall.
- **Illegal, RV32E.** NUM_REGS = 16, ADD x17,x1,x2 -> decode_illegal = 1, decode_regwr = 0, no scoreboard set. A 16-bit encoding (ir[1:0] = 2'b01) -> decode_illegal = 1.
- **Backpressure and WAW.** decode_rdy = 0 holds the entry stable with fetch_rdy = 0. A second write to a pending rd stalls until its regwr_en.
